// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
//   Definitions shared by the bit-serial adder controller and its bench:
//   the controller state encoding and the supported operand width ceiling.
// ---------------------------------------------------------------------------
package serial_add_pkg;

  // Widest operand the controller is qualified for.
  localparam int MAX_WIDTH = 32;

  // Controller states. Encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/Full_Adder.sv
// ---------------------------------------------------------------------------
// Full_Adder
//   Shared 1-bit full-adder cell.
//   Ports:
//     sum   out  a ^ b ^ c_in
//     c_out out  carry out of this bit
//     a, b  in   operand bits
//     c_in  in   carry into this bit
// ---------------------------------------------------------------------------
module Full_Adder (
  output logic sum,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ c_in;
  assign c_out    = (a & b) | (c_in & half_sum);

endmodule : Full_Adder

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller. Operands are accepted over a valid/ready
//   handshake and added LSB-first through a single Full_Adder cell, one bit
//   per clock, with the carry held in a register between bits. The WIDTH-bit
//   sum, the carry out of the MSB and the signed overflow flag are presented
//   over a valid/ready result handshake.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   synchronous active-low reset
//     in_valid   in   a, b, c_in valid
//     in_ready   out  controller idle and able to take operands
//     a, b       in   WIDTH-bit operands
//     c_in       in   carry into bit 0
//     out_valid  out  sum, c_out, ovf valid
//     out_ready  in   consumer takes the result
//     sum        out  a + b + c_in mod 2^WIDTH
//     c_out      out  carry out of the MSB
//     ovf        out  signed overflow (carry into MSB ^ carry out of MSB)
//
//   Timing: an operand accepted on edge E produces out_valid=1 right after
//   edge E+WIDTH. Minimum of WIDTH+2 cycles per operation.
// ---------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int                 CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be in 1..MAX_WIDTH");
  end

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] a_sr_q,      a_sr_d;
  logic [WIDTH-1:0] b_sr_q,      b_sr_d;
  logic [WIDTH-1:0] s_sr_q,      s_sr_d;
  logic             carry_q,     carry_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             c_out_q,     c_out_d;
  logic             ovf_q,       ovf_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Bit-serial datapath: the only adder logic in the block.
  logic fa_sum;
  logic fa_c_out;

  Full_Adder u_full_adder (
    .sum   (fa_sum),
    .c_out (fa_c_out),
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c_in  (carry_q)
  );

  // Sum register after this cycle's bit enters at the MSB end.
  logic [WIDTH-1:0] s_shift;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    s_shift            = s_sr_q >> 1;
    s_shift[WIDTH-1]   = fa_sum;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_shift;
        carry_d = fa_c_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // carry_q is the carry into the MSB on this last bit.
          sum_d   = s_shift;
          c_out_d = fa_c_out;
          ovf_d   = carry_q ^ fa_c_out;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are registered copies of the next-state decode, so
    // they come straight from flops with no path from in_valid/out_ready.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      // NOTE: the shift registers are not observable before being loaded, but
      // resetting them keeps the datapath free of X after reset for free.
      cnt_q       <= '0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      s_sr_q      <= '0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      s_sr_q      <= s_sr_d;
      carry_q     <= carry_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Directed vectors and multi-cycle sequences on an 8-bit instance, plus
//   randomized traffic on 1-, 8- and 32-bit instances checked against an
//   arithmetic reference model (a + b + c_in, overflow from operand signs).
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W      = 8;
  localparam int N_RAND = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed-test instance
  // -------------------------------------------------------------------------
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs [7];

  // One full operation from IDLE: accept, count latency, check result, hand off.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    bit rdy_bad;
    a         = ta;
    b         = tb_v;
    c_in      = tc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    check({tag, "_in_ready_idle"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 0;
    rdy_bad  = 1'b0;
    while (!out_valid && lat < 50) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) rdy_bad = 1'b1;
    check({tag, "_latency"}, lat, W);
    check({tag, "_in_ready_busy"}, rdy_bad, 0);
    check({tag, "_sum"}, sum, es);
    check({tag, "_c_out"}, c_out, ec);
    check({tag, "_ovf"}, ovf, eo);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_handoff_valid_ready"}, {out_valid, in_ready}, 2'b01);
  endtask

  // -------------------------------------------------------------------------
  // Randomized instances: WIDTH = 1, 8, 32
  // -------------------------------------------------------------------------
  logic rst_n_r;

  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int RW = (gi == 0) ? 1 : (gi == 1) ? 8 : 32;

    logic          r_in_valid;
    logic          r_in_ready;
    logic [RW-1:0] r_a;
    logic [RW-1:0] r_b;
    logic          r_cin;
    logic          r_out_valid;
    logic          r_out_ready;
    logic [RW-1:0] r_sum;
    logic          r_c_out;
    logic          r_ovf;
    logic [RW+1:0] exp_q [$];
    bit            done;

    serial_add_ctrl #(.WIDTH(RW)) dut_r (
      .clk       (clk),
      .rst_n     (rst_n_r),
      .in_valid  (r_in_valid),
      .in_ready  (r_in_ready),
      .a         (r_a),
      .b         (r_b),
      .c_in      (r_cin),
      .out_valid (r_out_valid),
      .out_ready (r_out_ready),
      .sum       (r_sum),
      .c_out     (r_c_out),
      .ovf       (r_ovf)
    );

    // Producer: random gaps, random operands, expected result queued on accept.
    initial begin
      int            gap;
      int            wait_cyc;
      bit            rdy;
      logic [RW:0]   full;
      logic          m_ovf;
      r_in_valid = 1'b0;
      r_a        = '0;
      r_b        = '0;
      r_cin      = 1'b0;
      wait (rst_n_r === 1'b1);
      @(posedge clk); #1;
      for (int k = 0; k < N_RAND; k++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          @(posedge clk); #1;
        end
        r_a   = RW'($urandom);
        r_b   = RW'($urandom);
        r_cin = 1'($urandom);
        full  = {1'b0, r_a} + {1'b0, r_b} + {{RW{1'b0}}, r_cin};
        // Signed overflow: both operands share a sign the result does not.
        m_ovf = (r_a[RW-1] == r_b[RW-1]) && (full[RW-1] != r_a[RW-1]);
        r_in_valid = 1'b1;
        wait_cyc   = 0;
        do begin
          rdy = r_in_ready;
          @(posedge clk); #1;
          wait_cyc++;
        end while (!rdy && wait_cyc < 500);
        r_in_valid = 1'b0;
        if (!rdy) begin
          check($sformatf("rand_w%0d_accept_timeout", RW), 0, 1);
          break;
        end
        exp_q.push_back({full[RW], m_ovf, full[RW-1:0]});
      end
    end

    // Consumer: random out_ready, compares every handed-off result in order.
    initial begin
      int            received;
      int            idle;
      bit            v;
      logic [RW+1:0] got;
      r_out_ready = 1'b0;
      received    = 0;
      idle        = 0;
      wait (rst_n_r === 1'b1);
      @(posedge clk); #1;
      while (received < N_RAND && idle < 2000) begin
        r_out_ready = ($urandom_range(0, 3) != 0);
        v   = r_out_valid;
        got = {r_c_out, r_ovf, r_sum};
        @(posedge clk); #1;
        if (v && r_out_ready) begin
          if (exp_q.size() == 0) begin
            check($sformatf("rand_w%0d_unexpected_result", RW), got, 0);
            failures++;
            checks++;
          end else begin
            check($sformatf("rand_w%0d_op%0d", RW, received), got, exp_q.pop_front());
          end
          received++;
          idle = 0;
        end else begin
          idle++;
        end
      end
      r_out_ready = 1'b0;
      check($sformatf("rand_w%0d_received", RW), received, N_RAND);
      check($sformatf("rand_w%0d_left_in_queue", RW), exp_q.size(), 0);
      done = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int cyc;
    int lat;

    vecs[0] = '{a: 8'h35, b: 8'h4A, cin: 1'b0, sum: 8'h7F, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 8'h7F, b: 8'h7F, cin: 1'b1, sum: 8'hFF, cout: 1'b0, ovf: 1'b1};
    vecs[6] = '{a: 8'hC3, b: 8'h3C, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};

    rst_n     = 1'b0;
    rst_n_r   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {in_ready, out_valid, sum, c_out, ovf}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    rst_n   = 1'b1;
    rst_n_r = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", {in_ready, out_valid}, 2'b10);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].sum, vecs[i].cout, vecs[i].ovf);
    end

    // Back-pressure with a stray in_valid held through ADD and DONE.
    a        = 8'h00;
    b        = 8'h00;
    c_in     = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    a   = 8'h55;
    b   = 8'h55;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_cycle%0d", i), {out_valid, in_ready, sum, c_out, ovf},
            {1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("no_second_result%0d", i), {out_valid, in_ready, sum}, {1'b0, 1'b1, 8'h01});
      @(posedge clk); #1;
    end

    // Reset during the third ADD cycle aborts the add.
    a        = 8'h55;
    b        = 8'h11;
    c_in     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_reset_state", {in_ready, out_valid, sum, c_out, ovf},
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_abort", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // Wait for randomized traffic to drain.
    cyc = 0;
    while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done) && cyc < 80000) begin
      @(posedge clk);
      cyc++;
    end
    check("random_traffic_complete",
          {g_rand[0].done, g_rand[1].done, g_rand[2].done}, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_add_ctrl
